// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and FSM state type for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_LAT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DRAIN_WAIT = 2'd1,
        ST_READ       = 2'd2,
        ST_DONE       = 2'd3
    } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_wbuf.sv
// ============================================================================
// Module      : dmem_wbuf
// Description : One-entry posted write buffer with drain counter and address compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int LAT    = DMEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic [ADDR_W-1:0] i_cmp_addr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_hit,
    output logic              o_drain_done,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data
);

    logic              r_valid;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_drain_done;

    // The capture cycle is drain cycle 1, so the entry stays visible for LAT-1 cycles.
    assign w_drain_done = r_valid && (r_cnt == 4'(LAT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_load && (LAT > 1)) begin
            r_valid <= 1'b1;
            r_cnt   <= 4'd1;
            r_addr  <= i_load_addr;
            r_data  <= i_load_data;
        end else if (w_drain_done) begin
            r_valid <= 1'b0;
            r_cnt   <= 4'd0;
        end else if (r_valid) begin
            r_cnt   <= r_cnt + 4'd1;
        end
    end

    generate
        if (LAT == 1) begin : g_direct
            assign o_wr_en   = i_load;
            assign o_wr_addr = i_load_addr;
            assign o_wr_data = i_load_data;
        end else begin : g_drained
            assign o_wr_en   = w_drain_done;
            assign o_wr_addr = r_addr;
            assign o_wr_data = r_data;
        end
    endgenerate

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_hit        = r_valid && (r_addr == i_cmp_addr);
    assign o_drain_done = w_drain_done;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage data-memory slave: posted writes, forwarded hits, stalled misses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int LAT    = DMEM_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              err
);

    localparam int         DEPTH        = 1 << ADDR_W;
    localparam logic [1:0] S_IDLE       = ST_IDLE;
    localparam logic [1:0] S_DRAIN_WAIT = ST_DRAIN_WAIT;
    localparam logic [1:0] S_READ       = ST_READ;
    localparam logic [1:0] S_DONE       = ST_DONE;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_rcnt;
    logic [3:0]        w_rcnt_nxt;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_rd;
    logic              w_hit_rd;
    logic              w_miss_rd;
    logic              w_wr_acc;
    logic              w_buf_valid;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_buf_hit;
    logic              w_drain_done;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    // A simultaneous read+write is handled as a write only.
    assign w_rd      = mem_read && !mem_write;
    assign w_hit_rd  = (r_state == S_IDLE) && w_rd && w_buf_hit;
    assign w_miss_rd = (r_state == S_IDLE) && w_rd && !w_buf_hit;
    assign stall     = (r_state == S_DRAIN_WAIT) || (r_state == S_READ) || w_miss_rd
                     || (mem_write && w_buf_valid);
    assign w_wr_acc  = mem_write && !stall;

    dmem_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LAT    (LAT)
    ) u_wbuf (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_wr_acc),
        .i_load_addr  (mem_addr),
        .i_load_data  (mem_wdata),
        .i_cmp_addr   (mem_addr),
        .o_valid      (w_buf_valid),
        .o_data       (w_buf_data),
        .o_hit        (w_buf_hit),
        .o_drain_done (w_drain_done),
        .o_wr_en      (w_wr_en),
        .o_wr_addr    (w_wr_addr),
        .o_wr_data    (w_wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // r_rcnt counts array read cycles already spent; the IDLE cycle of a clean miss is the first.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        case (r_state)
            S_IDLE: begin
                if (w_miss_rd) begin
                    if (w_buf_valid) begin
                        if (w_drain_done) begin
                            w_state_nxt = S_READ;
                            w_rcnt_nxt  = 4'd0;
                        end else begin
                            w_state_nxt = S_DRAIN_WAIT;
                        end
                    end else if (LAT == 1) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_READ;
                        w_rcnt_nxt  = 4'd1;
                    end
                end
            end
            S_DRAIN_WAIT: begin
                if (w_drain_done) begin
                    w_state_nxt = S_READ;
                    w_rcnt_nxt  = 4'd0;
                end
            end
            S_READ: begin
                if ((r_rcnt + 4'd1) == 4'(LAT)) begin
                    w_state_nxt = S_DONE;
                    w_rcnt_nxt  = 4'd0;
                end else begin
                    w_rcnt_nxt  = r_rcnt + 4'd1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rcnt  <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_rdata <= r_mem[mem_addr];
            end else if (w_hit_rd) begin
                r_rdata <= w_buf_data;
            end
            if (mem_read && mem_write) begin
                r_err <= 1'b1;
            end
        end
    end

    assign rdata_valid = (r_state == S_DONE) || w_hit_rd;
    assign mem_rdata   = w_hit_rd ? w_buf_data : r_rdata;
    assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed bench for dmem_responder with a cycle-timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [7:0]  mem_addr = 8'd0;
    logic [15:0] mem_wdata = 16'd0;
    logic [15:0] mem_rdata;
    logic        rdata_valid;
    logic        stall;
    logic        err;

    int checks = 0;
    int failures = 0;

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: a timeline of when the posted write lands and when a read completes.
    logic [15:0] m_mem [256];
    logic        p_valid;
    logic [7:0]  p_addr;
    logic [15:0] p_data;
    int          p_done;
    logic        r_busy;
    int          r_done;
    logic [15:0] r_val;
    logic [15:0] last;
    logic        m_err;
    logic        e_stall, e_valid, e_err;
    logic [15:0] e_data;
    int          rem;
    int          cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 16'd0;
            p_valid = 1'b0; r_busy = 1'b0; last = 16'd0; m_err = 1'b0;
        end else begin
            e_err = m_err; e_stall = 1'b0; e_valid = 1'b0; e_data = last;
            if (r_busy) begin
                e_stall = (cyc < r_done);
                if (cyc == r_done) begin
                    e_valid = 1'b1; e_data = r_val; last = r_val; r_busy = 1'b0;
                end
            end else if (mem_read && !mem_write) begin
                if (p_valid && p_addr == mem_addr) begin
                    e_valid = 1'b1; e_data = p_data; last = p_data;
                end else begin
                    rem = p_valid ? (p_done - cyc + 1) : 0;
                    r_done = cyc + rem + LAT;
                    r_val = m_mem[mem_addr];
                    r_busy = 1'b1;
                    e_stall = 1'b1;
                end
            end else if (mem_write) begin
                e_stall = p_valid;
                if (!p_valid) begin
                    p_valid = 1'b1; p_addr = mem_addr; p_data = mem_wdata; p_done = cyc + LAT - 1;
                end
            end
            check("model_stall", 32'(stall), 32'(e_stall));
            check("model_rdata_valid", 32'(rdata_valid), 32'(e_valid));
            check("model_mem_rdata", 32'(mem_rdata), 32'(e_data));
            check("model_err", 32'(err), 32'(e_err));
            if (p_valid && p_done == cyc) begin
                m_mem[p_addr] = p_data; p_valid = 1'b0;
            end
            if (mem_read && mem_write) m_err = 1'b1;
        end
        cyc++;
    end

    task automatic req(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d,
                       output int sc, output logic [15:0] data, output logic got_valid);
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = d;
        sc = 0; data = 16'd0; got_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!stall) begin
                got_valid = rdata_valid; data = mem_rdata;
                break;
            end
            sc++;
        end
        if (sc >= 40) check("req_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic do_wr(input logic [7:0] a, input logic [15:0] d, input int exp_sc);
        int sc; logic [15:0] data; logic gv;
        req(1'b0, 1'b1, a, d, sc, data, gv);
        check($sformatf("wr_stall_cycles@%0h", a), 32'(sc), 32'(exp_sc));
    endtask

    task automatic do_rd(input logic [7:0] a, input logic [15:0] exp_d, input int exp_sc);
        int sc; logic [15:0] data; logic gv;
        req(1'b1, 1'b0, a, 16'd0, sc, data, gv);
        check($sformatf("rd_stall_cycles@%0h", a), 32'(sc), 32'(exp_sc));
        check($sformatf("rd_valid@%0h", a), 32'(gv), 32'd1);
        check($sformatf("rd_data@%0h", a), 32'(data), 32'(exp_d));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int sc; logic [15:0] data; logic gv;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_rdata_valid", 32'(rdata_valid), 32'd0);
        check("reset_mem_rdata", 32'(mem_rdata), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        @(posedge clk); #1;

        // Reset mid-drain discards the buffered write.
        do_wr(8'd3, 16'h00AA, 0);
        do_reset();
        do_rd(8'd3, 16'h0000, LAT);

        // Posted write then miss on another address.
        do_wr(8'd5, 16'h1234, 0);
        do_rd(8'd7, 16'h0000, (LAT - 1) + LAT);
        do_rd(8'd5, 16'h1234, LAT);

        // Forwarding from the write buffer.
        do_wr(8'd9, 16'hBEEF, 0);
        do_rd(8'd9, 16'hBEEF, 0);
        idle(1);
        do_rd(8'd9, 16'hBEEF, LAT);

        // Back-to-back writes.
        do_wr(8'd1, 16'h1111, 0);
        do_wr(8'd2, 16'h2222, 1);
        idle(2);
        do_rd(8'd1, 16'h1111, LAT);
        do_rd(8'd2, 16'h2222, LAT);

        // Illegal request and address wrap.
        idle(2);
        req(1'b1, 1'b1, 8'hFF, 16'h5555, sc, data, gv);
        check("illegal_stall_cycles", 32'(sc), 32'd0);
        @(negedge clk);
        check("err_set", 32'(err), 32'd1);
        @(posedge clk); #1;
        do_rd(8'hFF, 16'h5555, LAT);
        do_rd(8'h00, 16'h0000, LAT);
        do_wr(8'h00, 16'hCAFE, 0);
        idle(1);
        do_rd(8'hFF, 16'h5555, LAT);
        do_rd(8'h00, 16'hCAFE, LAT);
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        check("rdata_held", 32'(mem_rdata), 32'h0000CAFE);
        @(posedge clk); #1;

        do_reset();
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        check("rdata_cleared", 32'(mem_rdata), 32'd0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
